// File: rtl/addr_data_rand.sv
// addr_data_rand: LFSR-based stimulus record generator (address, data, mask, r/w, delay).
// Three Galois right-shift LFSRs; outputs are a combinational decode of the current state.
module addr_data_rand #(
    parameter int          WR_PCT    = 80,
    parameter logic [31:0] SEED_DATA = 32'h0000_0001,
    parameter logic [31:0] SEED_ADDR = 32'h1234_5678,
    parameter logic [15:0] SEED_CTRL = 16'h0001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        seed_load_i,
    input  logic [31:0] seed_i,
    input  logic        next_i,
    output logic        valid_o,
    output logic        wr_o,
    output logic [3:0]  mask_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  delay_o
);
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    // r < WR_PCT with r = prod >> 8 is the same as prod < WR_PCT * 256
    localparam logic [15:0] WR_LIM  = 16'(WR_PCT * 256);

    logic [31:0] d_q, a_q;
    logic [15:0] c_q;
    logic [31:0] d_step, a_step, d_seed, a_seed;
    logic [15:0] c_step, c_seed;
    logic [14:0] prod;
    logic        advance;

    function automatic logic [31:0] step32(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS_32 : 32'h0);
    endfunction

    function automatic logic [15:0] step16(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? TAPS_16 : 16'h0);
    endfunction

    always_comb begin
        d_step  = step32(d_q);
        a_step  = step32(a_q);
        c_step  = step16(c_q);
        d_seed  = (seed_i == 32'h0) ? 32'h1 : seed_i;
        a_seed  = ((seed_i ^ 32'h5A5A_5A5A) == 32'h0) ? 32'h1 : seed_i ^ 32'h5A5A_5A5A;
        c_seed  = ((seed_i[15:0] ^ 16'hA5A5) == 16'h0) ? 16'h1 : seed_i[15:0] ^ 16'hA5A5;
        advance = next_i && valid_o;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            d_q     <= SEED_DATA;
            a_q     <= SEED_ADDR;
            c_q     <= SEED_CTRL;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b1;
            if (seed_load_i) begin
                d_q <= d_seed;
                a_q <= a_seed;
                c_q <= c_seed;
            end else if (advance) begin
                d_q <= d_step;
                a_q <= a_step;
                c_q <= c_step;
            end
        end
    end

    always_comb begin
        prod    = {7'b0, c_q[7:0]} * 15'd100;
        wr_o    = {1'b0, prod} < WR_LIM;
        mask_o  = (c_q[11:8] == 4'h0) ? 4'hF : c_q[11:8];
        delay_o = c_q[15:12];
        addr_o  = a_q & 32'h01FF_FFFC;
        data_o  = d_q;
    end
endmodule

// File: tb/tb_addr_data_rand.sv
// tb_addr_data_rand: directed checks of addr_data_rand, plus WR_PCT=0/100 builds on shared stimulus.
module tb_addr_data_rand;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        seed_load_i = 1'b0;
    logic [31:0] seed_i = 32'h0;
    logic        next_i = 1'b0;
    logic        valid, wr, valid0, wr0, valid100, wr100;
    logic [3:0]  mask, delay, mask0, delay0, mask100, delay100;
    logic [31:0] addr, data, addr0, data0, addr100, data100;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    addr_data_rand dut (
        .clk_i(clk), .rst_i(rst_i), .seed_load_i(seed_load_i), .seed_i(seed_i), .next_i(next_i),
        .valid_o(valid), .wr_o(wr), .mask_o(mask), .addr_o(addr), .data_o(data), .delay_o(delay)
    );
    addr_data_rand #(.WR_PCT(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .seed_load_i(seed_load_i), .seed_i(seed_i), .next_i(next_i),
        .valid_o(valid0), .wr_o(wr0), .mask_o(mask0), .addr_o(addr0), .data_o(data0), .delay_o(delay0)
    );
    addr_data_rand #(.WR_PCT(100)) dut100 (
        .clk_i(clk), .rst_i(rst_i), .seed_load_i(seed_load_i), .seed_i(seed_i), .next_i(next_i),
        .valid_o(valid100), .wr_o(wr100), .mask_o(mask100), .addr_o(addr100), .data_o(data100), .delay_o(delay100)
    );

    // record layout: {data, addr, mask, wr, delay}
    function automatic logic [72:0] cur();
        return {data, addr, mask, wr, delay};
    endfunction

    task automatic test_reset();
        rst_i = 1'b0; next_i = 1'b0; seed_load_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
        checks++;
        if (cur() !== {32'h1, 32'h0034_5678, 4'hF, 1'b1, 4'h0}) begin
            errors++; $display("FAIL reset_record got %h exp %h", cur(), {32'h1, 32'h0034_5678, 4'hF, 1'b1, 4'h0});
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL valid_before_edge got %0b exp 0", valid); end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL valid_rise got %0b exp 1", valid); end
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, cur()} !== {1'b1, 32'h1, 32'h0034_5678, 4'hF, 1'b1, 4'h0}) begin
            errors++; $display("FAIL reset_hold got %h exp %h", {valid, cur()}, {1'b1, 32'h1, 32'h0034_5678, 4'hF, 1'b1, 4'h0});
        end
    endtask

    task automatic test_next();
        next_i = 1'b1;
        @(negedge clk);
        next_i = 1'b0;
        checks++;
        if (cur() !== {32'h8020_0003, 32'h011A_2B3C, 4'h4, 1'b1, 4'hB}) begin
            errors++; $display("FAIL one_step got %h exp %h", cur(), {32'h8020_0003, 32'h011A_2B3C, 4'h4, 1'b1, 4'hB});
        end
        @(negedge clk);
        checks++;
        if (cur() !== {32'h8020_0003, 32'h011A_2B3C, 4'h4, 1'b1, 4'hB}) begin
            errors++; $display("FAIL step_hold got %h exp %h", cur(), {32'h8020_0003, 32'h011A_2B3C, 4'h4, 1'b1, 4'hB});
        end
    endtask

    task automatic test_next_while_invalid();
        rst_i = 1'b0;
        #1;
        next_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, data} !== {1'b1, 32'h1}) begin
            errors++; $display("FAIL next_ignored_invalid got %h exp %h", {valid, data}, {1'b1, 32'h1});
        end
        @(negedge clk);
        next_i = 1'b0;
        checks++;
        if (data !== 32'h8020_0003) begin errors++; $display("FAIL first_valid_step got %h exp 80200003", data); end
    endtask

    task automatic test_seed_priority();
        seed_i = 32'h0; seed_load_i = 1'b1; next_i = 1'b1;
        @(negedge clk);
        seed_load_i = 1'b0; next_i = 1'b0;
        checks++;
        if ({valid, cur()} !== {1'b1, 32'h1, 32'h005A_5A58, 4'h5, 1'b1, 4'hA}) begin
            errors++; $display("FAIL seed_zero got %h exp %h", {valid, cur()}, {1'b1, 32'h1, 32'h005A_5A58, 4'h5, 1'b1, 4'hA});
        end
        next_i = 1'b1;
        @(negedge clk);
        next_i = 1'b0;
        checks++;
        if (cur() !== {32'h8020_0003, 32'h012D_2D2C, 4'h6, 1'b0, 4'hE}) begin
            errors++; $display("FAIL seed_step got %h exp %h", cur(), {32'h8020_0003, 32'h012D_2D2C, 4'h6, 1'b0, 4'hE});
        end
        checks++;
        if ({wr0, wr100} !== 2'b01) begin errors++; $display("FAIL seed_step_pct got %b exp 01", {wr0, wr100}); end
    endtask

    task automatic test_seed_lockup();
        seed_i = 32'h5A5A_A5A5; seed_load_i = 1'b1;
        @(negedge clk);
        checks++;
        if (cur() !== {32'h5A5A_A5A5, 32'h0000_FFFC, 4'hF, 1'b1, 4'h0}) begin
            errors++; $display("FAIL ctrl_zero_fix got %h exp %h", cur(), {32'h5A5A_A5A5, 32'h0000_FFFC, 4'hF, 1'b1, 4'h0});
        end
        seed_i = 32'h5A5A_5A5A;
        @(negedge clk);
        seed_load_i = 1'b0;
        checks++;
        if (cur() !== {32'h5A5A_5A5A, 32'h0, 4'hF, 1'b0, 4'hF}) begin
            errors++; $display("FAIL addr_zero_fix got %h exp %h", cur(), {32'h5A5A_5A5A, 32'h0, 4'hF, 1'b0, 4'hF});
        end
        checks++;
        if ({wr0, wr100} !== 2'b01) begin errors++; $display("FAIL r99_pct got %b exp 01", {wr0, wr100}); end
    endtask

    task automatic test_stream();
        logic [31:0] md = 32'h1, ma = 32'h1234_5678;
        logic [15:0] mc = 16'h1;
        logic [3:0]  mm;
        int writes = 0, model_bad = 0, mask_zero = 0, addr_bad = 0, wr0_ones = 0, wr100_zeros = 0;
        rst_i = 1'b0;
        #1;
        next_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        next_i = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            mm = (mc[11:8] == 4'h0) ? 4'hF : mc[11:8];
            if (cur() !== {md, {7'b0, ma[24:2], 2'b00}, mm, (int'(mc[7:0]) * 100) / 256 < 80, mc[15:12]}) begin
                if (model_bad == 0) $display("first stream difference at %0d: got %h", i, cur());
                model_bad++;
            end
            writes += int'(wr);
            wr0_ones += int'(wr0);
            wr100_zeros += int'(!wr100);
            mask_zero += int'(mask == 4'h0);
            addr_bad += int'(addr[1:0] != 2'b00 || addr[31:25] != 7'h0);
            md = (md >> 1) ^ (md[0] ? 32'h8020_0003 : 32'h0);
            ma = (ma >> 1) ^ (ma[0] ? 32'h8020_0003 : 32'h0);
            mc = (mc >> 1) ^ (mc[0] ? 16'hB400 : 16'h0);
            @(negedge clk);
        end
        next_i = 1'b0;
        checks++;
        if (model_bad !== 0) begin errors++; $display("FAIL stream_model got %0d bad records exp 0", model_bad); end
        checks++;
        if (writes < 7800 || writes > 8200) begin errors++; $display("FAIL wr_fraction got %0d/10000 exp 7800..8200", writes); end
        checks++;
        if (mask_zero !== 0) begin errors++; $display("FAIL mask_nonzero got %0d zero masks exp 0", mask_zero); end
        checks++;
        if (addr_bad !== 0) begin errors++; $display("FAIL addr_range got %0d bad addrs exp 0", addr_bad); end
        checks++;
        if (wr0_ones !== 0) begin errors++; $display("FAIL wr_pct0 got %0d writes exp 0", wr0_ones); end
        checks++;
        if (wr100_zeros !== 0) begin errors++; $display("FAIL wr_pct100 got %0d reads exp 0", wr100_zeros); end
    endtask

    task automatic test_replay();
        logic [72:0] rec [37];
        rst_i = 1'b0;
        #1;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        next_i = 1'b1;
        for (int k = 0; k < 37; k++) begin
            rec[k] = cur();
            @(negedge clk);
        end
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({valid, data, addr} !== {1'b0, 32'h1, 32'h0034_5678}) begin
            errors++; $display("FAIL async_reset got %h exp %h", {valid, data, addr}, {1'b0, 32'h1, 32'h0034_5678});
        end
        next_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        next_i = 1'b1;
        for (int k = 0; k < 37; k++) begin
            checks++;
            if (cur() !== rec[k]) begin errors++; $display("FAIL replay_%0d got %h exp %h", k, cur(), rec[k]); end
            @(negedge clk);
        end
        next_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_next();
        test_next_while_invalid();
        test_seed_priority();
        test_seed_lockup();
        test_stream();
        test_replay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/addr_data_rand.md
# addr_data_rand

Hardware pseudo-random transaction generator for the SDRAM controller bench environment. It produces one stimulus record per request: a word-aligned byte address inside the 32 MB SDRAM space, 32-bit write data, a non-zero byte mask, a read/write decision with a programmable write percentage, and an inter-transaction delay. It sits between a sequencer and the controller's inport driver and replaces software randomization with a repeatable LFSR-based source.

## Interface
Parameters:
- `WR_PCT`, 80: write probability in percent, legal range 0..100.
- `SEED_DATA`, 32'h0000_0001: reset state of the data LFSR; must be non-zero.
- `SEED_ADDR`, 32'h1234_5678: reset state of the address LFSR; must be non-zero.
- `SEED_CTRL`, 16'h0001: reset state of the control LFSR; must be non-zero.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, asynchronous and active-low.
- `seed_load_i`  in  1  reseeds all LFSRs from `seed_i`.
- `seed_i`  in  32  new seed value.
- `next_i`  in  1  consume the current record and advance.
- `valid_o`  out  1  the current record is valid.
- `wr_o`  out  1  1 = write transaction, 0 = read transaction.
- `mask_o`  out  4  byte-enable mask; never 0.
- `addr_o`  out  32  byte address.
- `data_o`  out  32  write data.
- `delay_o`  out  4  idle cycles to insert after this transaction, range 0..15.

## Operation
- Three Galois right-shift LFSRs:
  - D: 32-bit data LFSR, taps 32'h8020_0003.
  - A: 32-bit address LFSR, taps 32'h8020_0003.
  - C: 16-bit control LFSR, taps 16'hB400.
- Step rule for every LFSR: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- Output decode is combinational from the current state:
  - `data_o` = D.
  - `addr_o` = {7'b0, A[24:2], 2'b00}. Bits [31:25] and [1:0] are always 0.
  - `r` = (C[7:0] * 100) >> 8, giving a value in 0..99. Use at least 15-bit intermediate width.
  - `wr_o` = (r < WR_PCT). WR_PCT=0 means never write; WR_PCT=100 means always write.
  - `mask_o` = C[11:8], except that a value of 0 is replaced by 4'hF.
  - `delay_o` = C[15:12].
- Advance: D, A and C each step exactly once when `next_i` && `valid_o` at a clock edge. `next_i` has no effect while `valid_o`=0.
- Reseed: when `seed_load_i` is high, the LFSRs load as follows:
  - D = seed_i.
  - A = seed_i ^ 32'h5A5A_5A5A.
  - C = seed_i[15:0] ^ 16'hA5A5.
  - Any loaded value that is zero is replaced by 1, to avoid LFSR lockup.
- `seed_load_i` has priority over `next_i` in the same cycle; no step occurs.
- Sequences are fully deterministic for a given seed, so a reset replays the same stream.

## Timing
- Reset (`rst_i`=0, asynchronous):
  - D=SEED_DATA, A=SEED_ADDR, C=SEED_CTRL, `valid_o`=0.
  - With default parameters the outputs are: `data_o`=32'h0000_0001, `addr_o`=32'h0034_5678, `wr_o`=1, `mask_o`=4'hF, `delay_o`=0.
- `valid_o` rises at the first rising edge after reset deassertion and then stays 1 until the next reset.
- A record consumed at edge N is replaced by the next record, visible after edge N (zero-wait throughput: one record per cycle when `next_i` is held high).
- Reseeding takes effect at the edge where `seed_load_i` is sampled; the outputs reflect the new seed in the following cycle. `valid_o` stays 1.
- Reset asserted mid-stream immediately restores the seed state and clears `valid_o`; any in-flight step is discarded.
- No output glitches on `next_i` alone: outputs change only after clock edges.

## Test plan
- Reset release, defaults, no `next_i` -> `valid_o` 0 then 1 one cycle later; `data_o`=0000_0001, `addr_o`=0034_5678, `mask_o`=F, `wr_o`=1, `delay_o`=0, all held stable.
- One `next_i` pulse -> `data_o`=8020_0003, `addr_o`=011A_2B3C, C=B400, so `mask_o`=4, `delay_o`=B, `wr_o`=1.
- `seed_load_i` with `seed_i`=0 -> D=1, A=5A5A_5A5A, C=A5A5, so `addr_o`=005A_5A58, `mask_o`=5, `delay_o`=A; check that `next_i` asserted in the same cycle is ignored.
- 10 000 consecutive `next_i` with WR_PCT=80 -> write fraction 0.78..0.82; `mask_o` never 0; `addr_o`[1:0]=0 and `addr_o`[31:25]=0 on every record; rebuild with WR_PCT=0 and 100 -> `wr_o` constant 0 and constant 1 respectively.
- Assert reset after 37 steps, release, and step again -> the first 37 records exactly match the pre-reset stream.
